// File: rtl/display_mux_pkg.sv
// Shared types and constants for the two-digit display multiplexer.
package display_mux_pkg;

  typedef enum logic [2:0] {IDLE, BLANK1, SHOW0, BLANK0, SHOW1} mux_state_t;

  localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Phase-length counter: counts up from zero after a clear and flags the cycle it reaches the limit.
module phase_timer #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] limit,
  output logic             done_c
);

  logic [DIV_W-1:0] count;

  // Clear wins over increment; the caller clears on every phase change, so the count never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign done_c = (count == limit);

endmodule

// File: rtl/display_mux_scheduler.sv
// Alternates two common-anode digits over one shared seven-segment decoder,
// with a blanking gap between digits to suppress ghosting.
module display_mux_scheduler
  import display_mux_pkg::*;
#(
  parameter int unsigned DIV_W        = 32,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  input  logic [3:0]       digit0,
  input  logic [3:0]       digit1,
  output logic [3:0]       hex_out,
  output logic             anode0_n,
  output logic             anode1_n,
  output logic             sel,
  output logic             frame_done
);

  localparam int unsigned BLANK_LIMIT = (BLANK_CYCLES == 0) ? 32'd0 : BLANK_CYCLES - 1;
  localparam mux_state_t  FIRST_STATE = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;
  localparam mux_state_t  AFTER_SHOW0 = (BLANK_CYCLES == 0) ? SHOW1 : BLANK0;
  localparam mux_state_t  AFTER_SHOW1 = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;

  mux_state_t       state;
  mux_state_t       state_d;
  logic [DIV_W-1:0] divisor_q;
  logic [DIV_W-1:0] limit_c;
  logic             done_c;
  logic             clear_c;
  logic             first_frame;

  phase_timer #(.DIV_W(DIV_W)) u_phase_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_c),
    .limit  (limit_c),
    .done_c (done_c)
  );

  // Next state and current phase limit; dropping enable overrides everything.
  always_comb begin
    state_d = state;
    limit_c = divisor_q;
    case (state)
      IDLE:   state_d = FIRST_STATE;
      BLANK1: begin
        limit_c = DIV_W'(BLANK_LIMIT);
        if (done_c) state_d = SHOW0;
      end
      SHOW0:  if (done_c) state_d = AFTER_SHOW0;
      BLANK0: begin
        limit_c = DIV_W'(BLANK_LIMIT);
        if (done_c) state_d = SHOW1;
      end
      SHOW1:  if (done_c) state_d = AFTER_SHOW1;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  assign clear_c = (state_d != state) || (state == IDLE);

  // Anodes follow the next state so they are lit exactly during the SHOW cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      anode0_n    <= ANODE_OFF;
      anode1_n    <= ANODE_OFF;
      hex_out     <= '0;
      sel         <= 1'b0;
      frame_done  <= 1'b0;
      divisor_q   <= '0;
      first_frame <= 1'b1;
    end else begin
      state      <= state_d;
      anode0_n   <= (state_d == SHOW0) ? ~ANODE_OFF : ANODE_OFF;
      anode1_n   <= (state_d == SHOW1) ? ~ANODE_OFF : ANODE_OFF;
      frame_done <= 1'b0;
      if (state_d == IDLE) first_frame <= 1'b1;
      if (state_d == SHOW0 && state != SHOW0) begin
        divisor_q   <= divisor;
        hex_out     <= digit0;
        sel         <= 1'b0;
        frame_done  <= ~first_frame;
        first_frame <= 1'b0;
      end
      if (state_d == SHOW1 && state != SHOW1) begin
        divisor_q <= divisor;
        hex_out   <= digit1;
        sel       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Bench for display_mux_scheduler: two instances (with and without blanking) against a phase-length model.
module tb_display_mux_scheduler;

  localparam int unsigned DW = 8;
  localparam int P_IDLE = 0, P_B1 = 1, P_S0 = 2, P_B0 = 3, P_S1 = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] divisor;
  logic [3:0]    digit0, digit1;
  logic [3:0]    hex_o [2];
  logic          an0_o [2];
  logic          an1_o [2];
  logic          sel_o [2];
  logic          fd_o  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         ph      [2];
  int         left    [2];
  logic [3:0] m_hex   [2];
  logic       m_sel   [2];
  logic       m_fd    [2];
  logic       m_first [2];
  int         fd_times[$];
  bit         rec = 1'b0;

  display_mux_scheduler #(.DIV_W(DW), .BLANK_CYCLES(2)) u_dut_b2 (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .digit0(digit0), .digit1(digit1), .hex_out(hex_o[0]),
    .anode0_n(an0_o[0]), .anode1_n(an1_o[0]), .sel(sel_o[0]), .frame_done(fd_o[0])
  );

  display_mux_scheduler #(.DIV_W(DW), .BLANK_CYCLES(0)) u_dut_b0 (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .digit0(digit0), .digit1(digit1), .hex_out(hex_o[1]),
    .anode0_n(an0_o[1]), .anode1_n(an1_o[1]), .sel(sel_o[1]), .frame_done(fd_o[1])
  );

  always #5 clk = ~clk;

  function automatic int blanks(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    ph[k]      = P_IDLE;
    left[k]    = 0;
    m_hex[k]   = 4'h0;
    m_sel[k]   = 1'b0;
    m_fd[k]    = 1'b0;
    m_first[k] = 1'b1;
  endtask

  // Start phase p: blanks last a fixed count, shows last divisor+1 from the value seen on entry.
  task automatic enter(input int k, input int p);
    ph[k] = p;
    case (p)
      P_B1, P_B0: left[k] = blanks(k);
      P_S0: begin
        left[k]    = int'(divisor) + 1;
        m_hex[k]   = digit0;
        m_sel[k]   = 1'b0;
        m_fd[k]    = !m_first[k];
        m_first[k] = 1'b0;
      end
      P_S1: begin
        left[k]  = int'(divisor) + 1;
        m_hex[k] = digit1;
        m_sel[k] = 1'b1;
      end
      default: left[k] = 0;
    endcase
  endtask

  task automatic model_step(input int k);
    m_fd[k] = 1'b0;
    if (!enable) begin
      ph[k]      = P_IDLE;
      m_first[k] = 1'b1;
    end else if (ph[k] == P_IDLE) begin
      enter(k, (blanks(k) == 0) ? P_S0 : P_B1);
    end else begin
      left[k]--;
      if (left[k] == 0) begin
        case (ph[k])
          P_B1:    enter(k, P_S0);
          P_S0:    enter(k, (blanks(k) == 0) ? P_S1 : P_B0);
          P_B0:    enter(k, P_S1);
          default: enter(k, (blanks(k) == 0) ? P_S0 : P_B1);
        endcase
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("anode0_n[%0d]", k), an0_o[k], ph[k] != P_S0);
      check($sformatf("anode1_n[%0d]", k), an1_o[k], ph[k] != P_S1);
      check($sformatf("hex_out[%0d]", k), hex_o[k], m_hex[k]);
      check($sformatf("sel[%0d]", k), sel_o[k], m_sel[k]);
      check($sformatf("frame_done[%0d]", k), fd_o[k], m_fd[k]);
      check($sformatf("no_overlap[%0d]", k), an0_o[k] | an1_o[k], 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all();
    if (rec && fd_o[0]) fd_times.push_back(cyc);
  endtask

  // Advance until the blanking instance lights the requested anode (bounded).
  task automatic wait_for(input int which, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      tick();
      found = ((which == 1) ? an1_o[0] : an0_o[0]) == 1'b0;
    end
    check(tag, found, 1);
  endtask

  initial begin
    logic prev;
    reset   = 1'b1;
    enable  = 1'b1;
    divisor = DW'(3);
    digit0  = 4'hA;
    digit1  = 4'h5;
    model_reset(0);
    model_reset(1);
    #1 reset = 1'b0;
    #1 check_all();
    tick();
    tick();
    #2 reset = 1'b1;

    // Nominal schedule, digit0 changed mid-SHOW0, frame period recorded.
    rec = 1'b1;
    wait_for(0, "wait_show0_a");
    digit0 = 4'h3;
    repeat (40) tick();
    rec = 1'b0;
    check("fd_pulses_seen", fd_times.size() >= 2, 1);
    for (int i = 1; i < fd_times.size(); i++)
      check("fd_period", fd_times[i] - fd_times[i-1], 12);

    // Enable dropped mid-SHOW1 for five cycles.
    wait_for(1, "wait_show1");
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    repeat (20) tick();

    // Asynchronous reset between clock edges during SHOW0.
    wait_for(0, "wait_show0_b");
    #3 reset = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_all();
    tick();
    #2 reset = 1'b1;
    repeat (20) tick();

    // Divisor changed 3 -> 7 mid-SHOW0.
    wait_for(0, "wait_show0_c");
    divisor = DW'(7);
    repeat (30) tick();

    // Randomized digits, divisor and enable glitches.
    repeat (400) begin
      if ($urandom_range(0, 9) == 0) digit0 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) digit1 = 4'($urandom);
      if ($urandom_range(0, 19) == 0) divisor = DW'($urandom_range(0, 6));
      enable = ($urandom_range(0, 29) != 0);
      tick();
    end
    enable = 1'b1;

    // Single-cycle phases: the no-blank instance alternates digits every cycle.
    divisor = '0;
    repeat (30) tick();
    for (int i = 0; i < 10; i++) begin
      prev = sel_o[1];
      tick();
      check("b0_sel_toggle", sel_o[1], !prev);
      check("b0_anode_alt", an0_o[1] ^ an1_o[1], 1);
    end

    // Maximum divisor must still terminate each SHOW phase.
    divisor = '1;
    repeat (600) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux_scheduler.md
Name: display_mux_scheduler

Overview:
- Time-multiplexes one shared seven-segment decoder between two common-anode digits.
- Alternates digit0/digit1 with a programmable on-time and a fixed blanking gap, which suppresses ghosting.
- Sits between the switch/nibble sources and the existing seven-segment decoder.
- Replaces the free-running clk_divider toggle as the display-select source in the two-display top level.

Parameters:
- DIV_W, 32, width of the divisor input and the phase counter.
- BLANK_CYCLES, 16, clk cycles with both anodes off between digits; 0 means no blank phase.

Ports:
- clk  in  1  system clock (HSOSC-derived)
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- enable  in  1  1 = multiplexing runs; 0 = display dark
- divisor  in  DIV_W  on-time per digit is divisor+1 clk cycles
- digit0  in  4  nibble for display 0
- digit1  in  4  nibble for display 1
- hex_out  out  4  nibble to shared seven-segment decoder
- anode0_n  out  1  active-low enable, display 0
- anode1_n  out  1  active-low enable, display 1
- sel  out  1  0 = digit0 phase, 1 = digit1 phase (held through the following blank)
- frame_done  out  1  one-cycle pulse when a full SHOW0..BLANK1 frame completes

Behaviour:
- States: IDLE, BLANK1, SHOW0, BLANK0, SHOW1.
- Reset (async, reset==0):
  - state=IDLE, counter=0.
  - anode0_n=1, anode1_n=1, hex_out=0, sel=0, frame_done=0.
- All outputs are registered and change only on posedge clk; there are no combinational anode paths.
- enable=0 in any state:
  - Next state is IDLE with counter=0.
  - Both anodes go off on that same edge.
  - hex_out and sel hold their values.
- Transitions (while enable=1):
  - IDLE -> BLANK1.
  - BLANK1 -> SHOW0 after BLANK_CYCLES cycles.
  - SHOW0 -> BLANK0 after divisor_q+1 cycles.
  - BLANK0 -> SHOW1 after BLANK_CYCLES cycles.
  - SHOW1 -> BLANK1 after divisor_q+1 cycles.
  - When BLANK_CYCLES=0, blank states are skipped (SHOW0 -> SHOW1 -> SHOW0 directly).
- Latching on entry to a SHOW state:
  - divisor is captured into divisor_q.
  - The matching digit is captured into hex_out.
  - sel is set: 0 for SHOW0, 1 for SHOW1.
  - Changes to divisor or digits mid-phase take effect at the next SHOW entry only.
- Anode timing:
  - anode0_n=0 exactly during SHOW0 cycles; anode1_n=0 exactly during SHOW1 cycles.
  - The two anodes are never low simultaneously, including across enable toggles and reset.
- Counter:
  - Zeroed on every state entry and incremented each cycle.
  - Phase ends when counter == limit (divisor_q or BLANK_CYCLES-1).
  - Counter is DIV_W bits and never wraps, since the limit is at most 2^DIV_W-1.
  - divisor=0 gives 1-cycle SHOW phases.
  - divisor=all-ones must still terminate.
- frame_done is 1 for the single cycle following the BLANK1 -> SHOW0 edge, except the first entry after IDLE.
- Reset mid-SHOW: anodes go off immediately (asynchronous); the FSM restarts from IDLE after release.
- enable re-asserted: the first lit digit is always digit0, preceded by one full BLANK1.

Decomposition:
- Package display_mux_pkg:
  - typedef enum logic [2:0] mux_state_t {IDLE, BLANK1, SHOW0, BLANK0, SHOW1}.
  - localparam ANODE_OFF = 1'b1.
- Sub-module phase_timer: DIV_W counter with clear, limit input and done output.
  - Clear has priority over increment.
  - Async active-low reset.
- The FSM and output registers stay in display_mux_scheduler.

Test Plan:
- divisor=3, BLANK_CYCLES=2, enable=1 from reset release:
  - 1 IDLE, 2 blank, 4 cycles anode0_n=0, 2 blank, 4 cycles anode1_n=0.
  - Period 12 cycles; frame_done pulses every 12 cycles from the 2nd frame.
- digit0=4'hA, digit1=4'h5; change digit0 to 4'h3 mid-SHOW0:
  - hex_out stays A until the next SHOW0 entry, then reads 3.
  - hex_out=5 throughout SHOW1.
- Drop enable mid-SHOW1 for 5 cycles, then raise it:
  - Both anodes are 1 on the next edge.
  - Restart goes IDLE -> BLANK1 (2 cycles) -> SHOW0 with digit0.
- Assert reset mid-SHOW0 (async, between clock edges):
  - anode0_n=1 and all outputs at reset values immediately, without waiting for a clk edge.
  - Normal sequence after release.
- BLANK_CYCLES=0, divisor=0:
  - anode0_n and anode1_n alternate every cycle, never both 0.
  - sel toggles every cycle.
- Throughout all tests, assertion: !(anode0_n==0 && anode1_n==0).
- Change divisor from 3 to 7 during SHOW0:
  - Current SHOW0 lasts 4 cycles.
  - Following SHOW1 lasts 8 cycles.
